tracker_sensor_array: RTL and testbench
=======================================

Name: tracker_sensor_array

Overview:
- Parametrised line-tracker front end: takes NUM_SENSORS raw IR track inputs, synchronises and debounces each one, and computes a signed line-position error.
- Drives a 3-bit steering command to the motor controller.
- A line-loss recovery FSM turns toward the last-seen side of the line. If the line is not found within a timeout, it stops and flags lost.

Parameters:
- NUM_SENSORS, 5, number of track channels; must be odd and >= 3; bit 0 = leftmost sensor; centre index C = (NUM_SENSORS-1)/2.
- DEBOUNCE, 4, consecutive cycles a synchronised input must differ before its debounced value flips; must be >= 1.
- LOST_TIMEOUT, 100, cycles spent in RECOVER before entering LOST; must be >= 1.
- SHARP_TH, 2, |err| above this value selects a sharp turn.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = run tracker; 0 = force IDLE.
- track  input  NUM_SENSORS  raw sensor inputs, active-low (0 = sensor over line).
- state  output  3  steering command: 000 stop, 001 turn left, 010 turn right, 011 forward, 100 sharp left, 101 sharp right.
- lost  output  1  high while in LOST.
- mode  output  2  FSM state: 00 IDLE, 01 TRACK, 10 RECOVER, 11 LOST.
- line_vec  output  NUM_SENSORS  debounced on-line vector (1 = on line).

Behaviour:
- Reset (reset=0, asynchronous) clears every register:
  - Outputs: state=000, lost=0, mode=IDLE, line_vec=0.
  - Internal: sync flops=1 (off line), debounce counters=0, last_dir=left, timer=0.
- Per-channel input path:
  - Two-flop synchroniser, then inversion, gives s[i].
  - Debounce counter: if s[i]==line_vec[i], counter clears to 0. Otherwise it increments; when the counter would reach DEBOUNCE, line_vec[i] takes s[i] and the counter clears.
  - Pulses shorter than DEBOUNCE cycles are ignored.
- Latency: a stable input change that is set up before edge 1 appears on line_vec at edge DEBOUNCE+2 and on state/mode at edge DEBOUNCE+3. All outputs are registered.
- Position (combinational on line_vec):
  - L = lowest set index, R = highest set index.
  - err = (L+R) - 2C, a signed value of width clog2(NUM_SENSORS)+2.
  - Classification:
    - err==0: forward.
    - err<0 and |err|<=SHARP_TH: turn left; err<0 and |err|>SHARP_TH: sharp left.
    - err>0 and |err|<=SHARP_TH: turn right; err>0 and |err|>SHARP_TH: sharp right.
  - last_dir updates to the sign of err whenever line_vec is nonzero and err!=0; it holds when err==0 or when line_vec==0.
- FSM transitions (evaluated each edge; enable=0 has highest priority in every state):
  - IDLE: state=stop. If enable=1, go to TRACK at the next edge.
  - TRACK:
    - line_vec all ones (finish bar): state=stop, remain in TRACK.
    - line_vec==0: go to RECOVER, timer=0, state=sharp turn toward last_dir on the same edge.
    - Otherwise: state = position classification.
  - RECOVER:
    - state = sharp left/right per last_dir; timer increments each cycle.
    - line_vec!=0: go to TRACK; state = classification of the current line_vec on the same edge.
    - Timer reaches LOST_TIMEOUT-1 with line_vec still 0: go to LOST.
    - Reacquisition takes priority over timeout on the same edge.
  - LOST: state=stop, lost=1. If line_vec!=0, go to TRACK (lost clears on that edge).
  - enable=0 in any state: go to IDLE, state=stop, lost=0, timer=0. Debounce and line_vec keep running.
- Reset asserted mid-operation returns everything to reset values immediately, with no cycle of stale command.

Test Plan (NUM_SENSORS=5, DEBOUNCE=4, LOST_TIMEOUT=100, SHARP_TH=2, enable=1):
- Centre, then left offset:
  - Release reset with track=5'b11011 (index 2 on) -> at edge 7: line_vec=00100, mode=TRACK, state=011.
  - Then track=5'b11101 (index 1 on) -> state=001 (err=-2).
- Edge offsets and two-sensor centre:
  - track=5'b11110 (index 0 on) -> state=100 (err=-4).
  - track=5'b01111 -> state=101.
  - track=5'b10111 (indices 3) plus index 1 off, i.e. 5'b10101 -> err=0 -> state=011.
- Glitch rejection: while centred, pulse track to 5'b11111 for 3 cycles -> line_vec stays 00100 and state stays 011 throughout.
- Loss and timeout:
  - From index 4 on (last_dir=right), set track=5'b11111 -> mode=RECOVER, state=101.
  - After 100 cycles -> mode=LOST, state=000, lost=1.
  - Restore 5'b11011 -> mode=TRACK, lost=0, state=011.
- Finish bar and enable: track=5'b00000 -> state=000, mode=TRACK; drop enable -> mode=IDLE, state=000 at the next edge.
- Async reset mid-RECOVER: assert reset between edges -> state=000, mode=IDLE, lost=0, line_vec=0 without waiting for clk.

Source files
------------

// File: rtl/tracker_sensor_array.sv
`default_nettype none
// ============================================================================
// Module   : tracker_sensor_array
// Purpose  : IR line-tracker front end. Debounced sensor vector, signed
//            position error, steering command and line-loss recovery FSM.
// Revision : 1.0  initial release
// ============================================================================
module tracker_sensor_array #(
  parameter int NUM_SENSORS  = 5,
  parameter int DEBOUNCE     = 4,
  parameter int LOST_TIMEOUT = 100,
  parameter int SHARP_TH     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] track,
  output logic [2:0]             state,
  output logic                   lost,
  output logic [1:0]             mode,
  output logic [NUM_SENSORS-1:0] line_vec
);

  localparam int c_idx_w = $clog2(NUM_SENSORS);
  localparam int c_err_w = c_idx_w + 2;
  localparam int c_cnt_w = $clog2(DEBOUNCE + 1);
  localparam int c_tmr_w = $clog2(LOST_TIMEOUT + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(DEBOUNCE - 1);
  localparam logic [c_tmr_w-1:0] c_tmr_last   = c_tmr_w'(LOST_TIMEOUT - 1);
  localparam logic [c_err_w-1:0] c_two_centre = c_err_w'(NUM_SENSORS - 1);

  localparam logic [2:0] c_cmd_stop   = 3'b000;
  localparam logic [2:0] c_cmd_left   = 3'b001;
  localparam logic [2:0] c_cmd_right  = 3'b010;
  localparam logic [2:0] c_cmd_fwd    = 3'b011;
  localparam logic [2:0] c_cmd_sleft  = 3'b100;
  localparam logic [2:0] c_cmd_sright = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_TRACK   = 2'b01,
    S_RECOVER = 2'b10,
    S_LOST    = 2'b11
  } tracker_mode_t;

  logic [NUM_SENSORS-1:0] r_sync1;
  logic [NUM_SENSORS-1:0] r_sync2;
  logic [NUM_SENSORS-1:0] w_s;
  logic [NUM_SENSORS-1:0] w_line_vec;

  // Synchroniser idles at all-ones so a reset looks like "no line seen".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= track;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = ~r_sync2;

  generate
    for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_chan
      logic [c_cnt_w-1:0] r_cnt;
      logic               r_on;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt <= '0;
          r_on  <= 1'b0;
        end else if (w_s[gi] == r_on) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
          r_on  <= w_s[gi];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_line_vec[gi] = r_on;
    end
  endgenerate

  // Position error from the outermost active sensors.
  logic [c_idx_w-1:0] w_lo;
  logic [c_idx_w-1:0] w_hi;
  logic [c_err_w-1:0] w_err;
  logic [c_err_w-1:0] w_abs;
  logic               w_any;
  logic               w_all;
  logic [2:0]         w_class;

  always_comb begin
    w_lo = '0;
    w_hi = '0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (w_line_vec[i]) w_lo = c_idx_w'(i);
    end
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (w_line_vec[i]) w_hi = c_idx_w'(i);
    end
  end

  assign w_any = |w_line_vec;
  assign w_all = &w_line_vec;
  assign w_err = c_err_w'(w_lo) + c_err_w'(w_hi) - c_two_centre;
  assign w_abs = w_err[c_err_w-1] ? (~w_err + 1'b1) : w_err;

  always_comb begin
    w_class = c_cmd_fwd;
    if (w_err != '0) begin
      if (w_err[c_err_w-1])
        w_class = (int'(w_abs) > SHARP_TH) ? c_cmd_sleft : c_cmd_left;
      else
        w_class = (int'(w_abs) > SHARP_TH) ? c_cmd_sright : c_cmd_right;
    end
  end

  // 1 = line last seen to the right, 0 = to the left.
  logic r_last_dir;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_last_dir <= 1'b0;
    else if (w_any && (w_err != '0))
      r_last_dir <= ~w_err[c_err_w-1];
  end

  tracker_mode_t      r_mode;
  tracker_mode_t      w_mode_nx;
  logic [2:0]         r_state;
  logic [2:0]         w_state_nx;
  logic               r_lost;
  logic               w_lost_nx;
  logic [c_tmr_w-1:0] r_timer;
  logic [c_tmr_w-1:0] w_timer_nx;
  logic [2:0]         w_sharp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode  <= S_IDLE;
      r_state <= c_cmd_stop;
      r_lost  <= 1'b0;
      r_timer <= '0;
    end else begin
      r_mode  <= w_mode_nx;
      r_state <= w_state_nx;
      r_lost  <= w_lost_nx;
      r_timer <= w_timer_nx;
    end
  end

  assign w_sharp = r_last_dir ? c_cmd_sright : c_cmd_sleft;

  // Commands are computed for the destination state so they take effect on
  // the same edge as the mode change.
  always_comb begin
    w_mode_nx  = r_mode;
    w_state_nx = c_cmd_stop;
    w_lost_nx  = 1'b0;
    w_timer_nx = r_timer;
    if (!enable) begin
      w_mode_nx  = S_IDLE;
      w_timer_nx = '0;
    end else begin
      case (r_mode)
        S_IDLE: begin
          w_mode_nx = S_TRACK;
        end
        S_TRACK: begin
          if (w_all) begin
            w_state_nx = c_cmd_stop;
          end else if (!w_any) begin
            w_mode_nx  = S_RECOVER;
            w_timer_nx = '0;
            w_state_nx = w_sharp;
          end else begin
            w_state_nx = w_class;
          end
        end
        S_RECOVER: begin
          if (w_any) begin
            w_mode_nx  = S_TRACK;
            w_state_nx = w_class;
          end else if (r_timer == c_tmr_last) begin
            w_mode_nx = S_LOST;
            w_lost_nx = 1'b1;
          end else begin
            w_timer_nx = r_timer + 1'b1;
            w_state_nx = w_sharp;
          end
        end
        S_LOST: begin
          if (w_any) begin
            w_mode_nx  = S_TRACK;
            w_state_nx = w_class;
          end else begin
            w_lost_nx = 1'b1;
          end
        end
        default: begin
          w_mode_nx = S_IDLE;
        end
      endcase
    end
  end

  assign state    = r_state;
  assign lost     = r_lost;
  assign mode     = r_mode;
  assign line_vec = w_line_vec;

endmodule
`default_nettype wire

// File: tb/tb_tracker_sensor_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_tracker_sensor_array
// Purpose  : Directed self-checking bench for tracker_sensor_array.
// Revision : 1.0  initial release
// ============================================================================
module tb_tracker_sensor_array;

  logic       r_clk;
  logic       r_reset;
  logic       r_enable;
  logic [4:0] r_track;
  logic [2:0] w_state;
  logic       w_lost;
  logic [1:0] w_mode;
  logic [4:0] w_line_vec;

  int n_checks;
  int n_errors;

  tracker_sensor_array #(
    .NUM_SENSORS  (5),
    .DEBOUNCE     (4),
    .LOST_TIMEOUT (100),
    .SHARP_TH     (2)
  ) u_dut (
    .clk      (r_clk),
    .reset    (r_reset),
    .enable   (r_enable),
    .track    (r_track),
    .state    (w_state),
    .lost     (w_lost),
    .mode     (w_mode),
    .line_vec (w_line_vec)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; returns at the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge r_clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    r_reset  = 1'b0;
    r_enable = 1'b1;
    r_track  = 5'b11011;

    tick(3);
    check("rst_state", w_state, 3'b000);
    check("rst_mode", w_mode, 2'b00);
    check("rst_lost", w_lost, 1'b0);
    check("rst_line", w_line_vec, 5'b00000);

    // Centre sensor on: line_vec at edge 6, command at edge 7.
    r_reset = 1'b1;
    tick(5);
    check("lat_line_e5", w_line_vec, 5'b00000);
    tick(1);
    check("lat_line_e6", w_line_vec, 5'b00100);
    tick(1);
    check("centre_mode", w_mode, 2'b01);
    check("centre_state", w_state, 3'b011);
    check("centre_lost", w_lost, 1'b0);

    r_track = 5'b11101;
    tick(8);
    check("left1_line", w_line_vec, 5'b00010);
    check("left1_state", w_state, 3'b001);

    r_track = 5'b11110;
    tick(8);
    check("left0_state", w_state, 3'b100);

    r_track = 5'b01111;
    tick(8);
    check("right4_state", w_state, 3'b101);

    r_track = 5'b10101;
    tick(8);
    check("pair_line", w_line_vec, 5'b01010);
    check("pair_state", w_state, 3'b011);

    // Glitch shorter than the debounce window.
    r_track = 5'b11011;
    tick(8);
    r_track = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("glitch_line", w_line_vec, 5'b00100);
      check("glitch_state", w_state, 3'b011);
    end
    r_track = 5'b11011;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("glitch_line", w_line_vec, 5'b00100);
      check("glitch_state", w_state, 3'b011);
    end

    // Loss on the right, then timeout.
    r_track = 5'b01111;
    tick(8);
    check("pre_loss_state", w_state, 3'b101);
    r_track = 5'b11111;
    tick(6);
    check("loss_line", w_line_vec, 5'b00000);
    check("loss_mode_pre", w_mode, 2'b01);
    tick(1);
    check("recover_mode", w_mode, 2'b10);
    check("recover_state", w_state, 3'b101);
    tick(99);
    check("timeout_edge_mode", w_mode, 2'b10);
    check("timeout_edge_lost", w_lost, 1'b0);
    tick(1);
    check("lost_mode", w_mode, 2'b11);
    check("lost_state", w_state, 3'b000);
    check("lost_flag", w_lost, 1'b1);

    r_track = 5'b11011;
    tick(6);
    check("lost_hold", w_lost, 1'b1);
    tick(1);
    check("reacq_mode", w_mode, 2'b01);
    check("reacq_lost", w_lost, 1'b0);
    check("reacq_state", w_state, 3'b011);

    // Finish bar, then enable drop.
    r_track = 5'b00000;
    tick(8);
    check("bar_line", w_line_vec, 5'b11111);
    check("bar_state", w_state, 3'b000);
    check("bar_mode", w_mode, 2'b01);
    r_enable = 1'b0;
    tick(1);
    check("disable_mode", w_mode, 2'b00);
    check("disable_state", w_state, 3'b000);

    // Into RECOVER again, then asynchronous reset between edges.
    r_enable = 1'b1;
    r_track  = 5'b11111;
    tick(1);
    check("reenable_mode", w_mode, 2'b01);
    tick(10);
    check("recover2_mode", w_mode, 2'b10);
    check("recover2_state", w_state, 3'b101);
    #2;
    r_reset = 1'b0;
    #1;
    check("async_state", w_state, 3'b000);
    check("async_mode", w_mode, 2'b00);
    check("async_lost", w_lost, 1'b0);
    check("async_line", w_line_vec, 5'b00000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
